// File: rtl/game_pkg.sv
// Shared game definitions: timer state encoding, BCD digit limits and level start values.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_HALT,
    ST_EXPIRED
  } timer_state_e;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Start values handed out by level_control, two BCD digits each.
  localparam logic [7:0] LEVEL_EASY_BCD   = 8'h60;
  localparam logic [7:0] LEVEL_MEDIUM_BCD = 8'h45;
  localparam logic [7:0] LEVEL_HARD_BCD   = 8'h30;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

  // Converts a small integer (saturated at 99) into two packed BCD digits.
  function automatic logic [7:0] int_to_bcd8(input int unsigned v);
    int unsigned c;
    c = (v > 99) ? 99 : v;
    return {4'(c / 10), 4'(c % 10)};
  endfunction

endpackage

// File: rtl/bcd_sub_sat.sv
// Two-digit BCD subtractor of an 8-bit BCD amount; result saturates at 00 and flags zero.
module bcd_sub_sat
  import game_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_ten,
  input  logic [DIGIT_W-1:0] a_one,
  input  logic [7:0]         amount,
  output logic [DIGIT_W-1:0] r_ten,
  output logic [DIGIT_W-1:0] r_one,
  output logic               zero
);

  logic [DIGIT_W-1:0] b_ten;
  logic [DIGIT_W-1:0] b_one;
  logic               borrow;
  logic [DIGIT_W:0]   ten_need;

  always_comb begin
    b_ten    = amount[7:4];
    b_one    = amount[3:0];
    borrow   = (a_one < b_one);
    ten_need = {1'b0, b_ten} + {{DIGIT_W{1'b0}}, borrow};
    r_ten    = '0;
    r_one    = '0;
    // Underflow of the tens digit means the amount exceeds the value: saturate.
    if ({1'b0, a_ten} >= ten_need) begin
      r_ten = a_ten - ten_need[DIGIT_W-1:0];
      r_one = borrow ? (a_one + 4'd10 - b_one) : (a_one - b_one);
    end
    zero = (r_ten == '0) && (r_one == '0);
  end

endmodule

// File: rtl/countdown_timer.sv
// Bomb countdown: loads a BCD start value, decrements once per second while running,
// applies wrong-wire penalties and reports expiry.
module countdown_timer
  import game_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int PENALTY_SEC = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_ten,
  input  logic [DIGIT_W-1:0] load_one,
  input  logic               start,
  input  logic               enable,
  input  logic               penalty,
  input  logic               defused,
  output logic [DIGIT_W-1:0] time_ten,
  output logic [DIGIT_W-1:0] time_one,
  output logic               running,
  output logic               expired,
  output logic               sec_tick
);

  localparam int                   PRESC_W     = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST  = PRESC_W'(CLK_PER_SEC - 1);
  localparam logic [7:0]           PENALTY_BCD = int_to_bcd8(PENALTY_SEC);

  timer_state_e        state_q, state_d;
  logic [DIGIT_W-1:0]  ten_q, ten_d, one_q, one_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                sec_tick_q, sec_tick_d;
  logic                running_q, running_d;
  logic                expired_q, expired_d;

  logic                tick;
  logic [DIGIT_W-1:0]  dec_ten, dec_one, pen_ten, pen_one;
  logic                dec_zero, pen_zero;

  bcd_sub_sat u_dec (
    .a_ten (ten_q),
    .a_one (one_q),
    .amount(8'h01),
    .r_ten (dec_ten),
    .r_one (dec_one),
    .zero  (dec_zero)
  );

  bcd_sub_sat u_pen (
    .a_ten (ten_q),
    .a_one (one_q),
    .amount(PENALTY_BCD),
    .r_ten (pen_ten),
    .r_one (pen_one),
    .zero  (pen_zero)
  );

  assign tick = enable && (presc_q == PRESC_LAST);

  always_comb begin
    state_d    = state_q;
    ten_d      = ten_q;
    one_d      = one_q;
    presc_d    = presc_q;
    sec_tick_d = 1'b0;

    if (load) begin
      state_d = ST_ARMED;
      ten_d   = clamp_digit(load_ten);
      one_d   = clamp_digit(load_one);
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (start) begin
            state_d = ((ten_q == '0) && (one_q == '0)) ? ST_EXPIRED : ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          if (enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
          end
          // A penalty on a tick edge replaces the decrement but the tick still shows.
          if (defused) begin
            state_d = ST_HALT;
          end else if (penalty) begin
            ten_d      = pen_ten;
            one_d      = pen_one;
            sec_tick_d = tick;
            if (pen_zero) state_d = ST_EXPIRED;
          end else if (tick) begin
            ten_d      = dec_ten;
            one_d      = dec_one;
            sec_tick_d = 1'b1;
            if (dec_zero) state_d = ST_EXPIRED;
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ten_q      <= '0;
      one_q      <= '0;
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ten_q      <= ten_d;
      one_q      <= one_d;
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
    end
  end

  assign time_ten = ten_q;
  assign time_one = one_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scenario bench for countdown_timer with a 4-cycle second and 5-second penalty.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_ten = '0;
  logic [3:0] load_one = '0;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       penalty = 1'b0;
  logic       defused = 1'b0;
  logic [3:0] time_ten, time_one;
  logic       running, expired, sec_tick;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.CLK_PER_SEC(4), .PENALTY_SEC(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_ten(load_ten),
    .load_one(load_one),
    .start   (start),
    .enable  (enable),
    .penalty (penalty),
    .defused (defused),
    .time_ten(time_ten),
    .time_one(time_one),
    .running (running),
    .expired (expired),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load_ten = t; load_one = o; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({time_ten, time_one, running, expired, sec_tick} !== 11'h000) begin
      bad++; $display("FAIL reset_state got=%h req=000", {time_ten, time_one, running, expired, sec_tick});
    end
    do_start();
    total++;
    if ({time_ten, time_one, running} !== 9'h000) begin
      bad++; $display("FAIL start_no_load got=%h req=000", {time_ten, time_one, running});
    end
    enable = 1'b1;
    do_load(4'd1, 4'd2);
    do_start();
    step(); step();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({time_ten, time_one, running, expired} !== 10'h000) begin
      bad++; $display("FAIL async_reset got=%h req=000", {time_ten, time_one, running, expired});
    end
    #1 rst = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_countdown();
    int v;
    enable = 1'b1;
    do_load(4'd1, 4'd2);
    do_start();
    for (int k = 1; k <= 48; k++) begin
      step();
      v = 12 - k / 4;
      total++;
      if ({time_ten, time_one} !== bcd(v)) begin
        bad++; $display("FAIL countdown_value k=%0d got=%h req=%h", k, {time_ten, time_one}, bcd(v));
      end
      total++;
      if ({sec_tick, running, expired} !== {(k % 4) == 0, v != 0, v == 0}) begin
        bad++; $display("FAIL countdown_flags k=%0d got=%b req=%b", k, {sec_tick, running, expired},
                        {(k % 4) == 0, v != 0, v == 0});
      end
    end
    $display("countdown: final value %h expired=%b", {time_ten, time_one}, expired);
  endtask

  task automatic test_pause();
    enable = 1'b1;
    do_load(4'd0, 4'd5);
    do_start();
    for (int k = 0; k < 6; k++) step();
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if ({time_ten, time_one, sec_tick} !== {8'h04, 1'b0}) begin
        bad++; $display("FAIL pause_hold k=%0d got=%h req=%h", k, {time_ten, time_one, sec_tick}, {8'h04, 1'b0});
      end
    end
    enable = 1'b1;
    step();
    total++;
    if ({time_ten, time_one, sec_tick} !== {8'h04, 1'b0}) begin
      bad++; $display("FAIL resume_first got=%h req=%h", {time_ten, time_one, sec_tick}, {8'h04, 1'b0});
    end
    step();
    total++;
    if ({time_ten, time_one, sec_tick} !== {8'h03, 1'b1}) begin
      bad++; $display("FAIL resume_tick got=%h req=%h", {time_ten, time_one, sec_tick}, {8'h03, 1'b1});
    end
    $display("pause: resumed at %h", {time_ten, time_one});
  endtask

  task automatic test_penalty();
    enable = 1'b1;
    do_load(4'd0, 4'd7);
    do_start();
    penalty = 1'b1; step(); penalty = 1'b0;
    total++;
    if ({time_ten, time_one, running, expired} !== {8'h02, 2'b10}) begin
      bad++; $display("FAIL penalty_07 got=%h req=%h", {time_ten, time_one, running, expired}, {8'h02, 2'b10});
    end
    penalty = 1'b1; step(); penalty = 1'b0;
    total++;
    if ({time_ten, time_one, running, expired} !== {8'h00, 2'b01}) begin
      bad++; $display("FAIL penalty_sat got=%h req=%h", {time_ten, time_one, running, expired}, {8'h00, 2'b01});
    end
    penalty = 1'b1; step(); penalty = 1'b0;
    total++;
    if ({time_ten, time_one, running, expired} !== {8'h00, 2'b01}) begin
      bad++; $display("FAIL penalty_after_exp got=%h req=%h", {time_ten, time_one, running, expired}, {8'h00, 2'b01});
    end
    $display("penalty: value %h expired=%b", {time_ten, time_one}, expired);
  endtask

  task automatic test_defuse_simul();
    enable = 1'b1;
    do_load(4'd3, 4'd0);
    do_start();
    step(); step(); step();
    defused = 1'b1; step(); defused = 1'b0;
    total++;
    if ({time_ten, time_one, running, expired} !== {8'h30, 2'b00}) begin
      bad++; $display("FAIL defuse_on_tick got=%h req=%h", {time_ten, time_one, running, expired}, {8'h30, 2'b00});
    end
    for (int k = 0; k < 6; k++) step();
    total++;
    if ({time_ten, time_one, running} !== {8'h30, 1'b0}) begin
      bad++; $display("FAIL halt_hold got=%h req=%h", {time_ten, time_one, running}, {8'h30, 1'b0});
    end
    do_load(4'd0, 4'd9);
    do_start();
    penalty = 1'b1;
    do_load(4'd3, 4'd5);
    penalty = 1'b0;
    total++;
    if ({time_ten, time_one, running, expired} !== {8'h35, 2'b00}) begin
      bad++; $display("FAIL load_vs_penalty got=%h req=%h", {time_ten, time_one, running, expired}, {8'h35, 2'b00});
    end
    do_start();
    step(); step(); step();
    penalty = 1'b1; step(); penalty = 1'b0;
    total++;
    if ({time_ten, time_one, sec_tick, running} !== {8'h30, 2'b11}) begin
      bad++; $display("FAIL penalty_on_tick got=%h req=%h", {time_ten, time_one, sec_tick, running}, {8'h30, 2'b11});
    end
    $display("defuse_simul: value %h", {time_ten, time_one});
  endtask

  task automatic test_edges();
    enable = 1'b1;
    do_load(4'd0, 4'd0);
    do_start();
    total++;
    if ({time_ten, time_one, running, expired} !== {8'h00, 2'b01}) begin
      bad++; $display("FAIL start_at_00 got=%h req=%h", {time_ten, time_one, running, expired}, {8'h00, 2'b01});
    end
    do_load(4'hF, 4'hA);
    total++;
    if ({time_ten, time_one, expired} !== {8'h99, 1'b0}) begin
      bad++; $display("FAIL clamp_load got=%h req=%h", {time_ten, time_one, expired}, {8'h99, 1'b0});
    end
    do_start();
    for (int k = 0; k < 4; k++) step();
    total++;
    if ({time_ten, time_one, sec_tick} !== {8'h98, 1'b1}) begin
      bad++; $display("FAIL from_99 got=%h req=%h", {time_ten, time_one, sec_tick}, {8'h98, 1'b1});
    end
    $display("edges: value %h", {time_ten, time_one});
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_penalty();
    test_defuse_simul();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
